mem_access_unit: RTL and testbench

Multi-cycle load/store sequencer between the datapath and data memory in the CPU. It accepts one access request, drives a request/acknowledge handshake to data memory, and performs little-endian byte-lane steering. Load results go out raw: the selected byte feeds the 8-bit sign/zero extender, the selected halfword feeds the 16-bit extender, and the full word goes straight to write-back. It flags misaligned accesses and memory timeouts without corrupting memory.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/lane_steer.sv | 19 +
 rtl/mem_access_unit.sv | 108 ++++++++++
 tb/tb_mem_access_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings and helpers for the CPU memory path
package cpu_pkg;
  localparam int CNT_W = 10;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  // size 2'b11 falls into the word rule
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_HALF ? lane[0] : size == SZ_BYTE ? 1'b0 : |lane;
  endfunction
endpackage

// File: rtl/lane_steer.sv
// lane_steer: little-endian byte-lane steering for stores and load extraction
module lane_steer
  import cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [31:0] rword,
  input  logic [1:0]  rlane,
  output logic [7:0]  rdata8,
  output logic [15:0] rdata16
);
  assign be = size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  assign rdata8 = 8'(rword >> {rlane, 3'b000});
  assign rdata16 = rlane[1] ? rword[31:16] : rword[15:0];
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer with dm_req/dm_ack handshake,
// lane steering, misalignment and timeout reporting
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        err,
  output logic [7:0]  rdata8,
  output logic [15:0] rdata16,
  output logic [31:0] rdata32,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lane;
  logic [1:0]       ld_lane;
  logic [3:0]       be_n;
  logic [31:0]      wd_n;
  assign busy = state != IDLE;
  // ld_lane tracks the last successful load so rdata8/16 hold with rdata32
  lane_steer u_steer (
    .size      (size),
    .lane      (addr[1:0]),
    .wdata     (wdata),
    .be        (be_n),
    .wdata_rep (wd_n),
    .rword     (rdata32),
    .rlane     (ld_lane),
    .rdata8    (rdata8),
    .rdata16   (rdata16)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      lane     <= '0;
      ld_lane  <= '0;
      done     <= 1'b0;
      misalign <= 1'b0;
      err      <= 1'b0;
      rdata32  <= '0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_be    <= '0;
      dm_addr  <= '0;
      dm_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (misaligned(size, addr[1:0])) begin
            state    <= DONE;
            done     <= 1'b1;
            misalign <= 1'b1;
          end else begin
            state    <= REQ;
            cnt      <= '0;
            lane     <= addr[1:0];
            dm_req   <= 1'b1;
            dm_we    <= we;
            dm_be    <= be_n;
            dm_addr  <= {addr[31:2], 2'b00};
            dm_wdata <= wd_n;
          end
        end
        REQ: if (dm_ack) begin
          state  <= DONE;
          done   <= 1'b1;
          dm_req <= 1'b0;
          if (!dm_we) begin
            rdata32 <= dm_rdata;
            ld_lane <= lane;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            err    <= 1'b1;
            dm_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          misalign <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench with a byte-arithmetic reference model
module tb_mem_access_unit;
  localparam int TO = 4;
  logic        clk = 0;
  logic        rstn = 0;
  logic        start = 0;
  logic        we = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0;
  logic [31:0] wdata = 0;
  logic        busy, done, misalign, err;
  logic [7:0]  rdata8;
  logic [15:0] rdata16;
  logic [31:0] rdata32;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack = 0;
  logic [31:0] dm_rdata = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .misalign(misalign), .err(err),
    .rdata8(rdata8), .rdata16(rdata16), .rdata32(rdata32), .dm_req(dm_req),
    .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mis, err, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rword, r32;
    logic [7:0]  r8;
    logic [15:0] r16;
    int          waits, c0;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          rc = 0;
  int          reqcnt = 0;
  logic [31:0] m_word = 0;
  logic [1:0]  m_lane = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return 160'({busy, done, misalign, err, rdata8, rdata16, rdata32,
                 dm_req, dm_we, dm_be, dm_addr, dm_wdata});
  endfunction

  // Reference: byte count per size, alignment by modulo, replication by shifting
  task automatic issue(input logic iwe, input logic [1:0] isz, input logic [31:0] iaddr,
                       input logic [31:0] iwdata, input logic [31:0] irword, input int iwaits);
    exp_t   e;
    int     nb, k;
    longint mask, rep;
    nb = isz == 0 ? 1 : isz == 1 ? 2 : 4;
    e.mis = (iaddr % nb) != 0;
    e.err = !e.mis && iwaits >= TO;
    e.we = iwe;
    e.addr = iaddr & ~32'd3;
    e.be = 4'(((1 << nb) - 1) << (iaddr % 4));
    mask = (longint'(1) << (8 * nb)) - 1;
    rep = 0;
    for (int i = 0; i < 4 / nb; i++) rep |= (longint'(iwdata) & mask) << (8 * nb * i);
    e.wdata = rep[31:0];
    e.waits = iwaits;
    e.rword = irword;
    if (!e.mis && !e.err && !iwe) begin
      m_word = irword;
      m_lane = iaddr[1:0];
    end
    e.r32 = m_word;
    e.r8 = 8'(m_word >> (8 * m_lane));
    e.r16 = 16'(m_word >> (16 * (m_lane / 2)));
    e.c0 = cyc;
    q.push_back(e);
    we = iwe; size = isz; addr = iaddr; wdata = iwdata; start = 1;
    @(negedge clk);
    k = 0;
    while (busy && k < 40) begin
      start = 1'($urandom);
      we = 1'($urandom);
      size = 2'($urandom);
      addr = $urandom;
      wdata = $urandom;
      @(negedge clk);
      k++;
    end
    start = 0;
    if (k >= 40) check("busy_bound", 160'(k), 160'(0));
  endtask

  // Memory responder: acks after the scripted wait count, noise ack when idle
  always @(negedge clk) begin
    if (dm_req && q.size() > 0) begin
      dm_ack = rc == q[0].waits;
      dm_rdata = dm_ack ? q[0].rword : $urandom;
      rc++;
    end else begin
      dm_ack = !dm_req && ($urandom % 4 == 0);
      dm_rdata = $urandom;
      rc = 0;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (dm_req) begin
        reqcnt++;
        if (q.size() > 0)
          check("dm_bus", 160'({dm_we, dm_be, dm_addr, dm_wdata}),
                160'({q[0].we, q[0].be, q[0].addr, q[0].wdata}));
      end
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 160'(1), 160'(0));
        end else begin
          mon_e = q.pop_front();
          check("status", 160'({misalign, err}), 160'({mon_e.mis, mon_e.err}));
          check("rdata", 160'({rdata8, rdata16, rdata32}), 160'({mon_e.r8, mon_e.r16, mon_e.r32}));
          check("latency", 160'(cyc - mon_e.c0),
                160'(mon_e.mis ? 1 : mon_e.err ? TO + 1 : mon_e.waits + 2));
          check("req_cycles", 160'(reqcnt), 160'(mon_e.mis ? 0 : mon_e.err ? TO : mon_e.waits + 1));
        end
      end
      if (!dm_req) reqcnt = 0;
    end
  end

  initial begin
    int k;
    #12 check("reset", all_outs(), 160'(0));
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    issue(0, 2'b00, 32'h1003, $urandom, 32'hA1B2C3D4, 0);
    check("byte_load_r8", 160'(rdata8), 160'(8'hA1));
    start = 1; we = 0; size = 2'b10; addr = 32'h40;
    @(negedge clk);
    start = 0;
    check("req_before_reset", 160'(dm_req), 160'(1));
    #2 rstn = 0;
    #1 check("reset_mid_req", all_outs(), 160'(0));
    m_word = 0;
    m_lane = 0;
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    issue(1, 2'b01, 32'h2002, 32'h0000BEEF, $urandom, 3);
    issue(0, 2'b10, 32'h3002, $urandom, $urandom, 0);
    issue(0, 2'b10, 32'h3000, $urandom, $urandom, TO);
    issue(1, 2'b00, 32'h5001, $urandom, $urandom, TO - 1);
    issue(0, 2'b01, 32'h6002, $urandom, $urandom, TO - 1);
    for (int i = 0; i < 200; i++)
      issue(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, TO));
    k = 0;
    while (q.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) check("drain", 160'(q.size()), 160'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
